// File: rtl/control_filtro_pa5000.sv
// Six-step sequencer for the 5 kHz high-pass biquad MAC datapath (Moore FSM, registered outputs).
// Optional sticky overrun flag: define CTRLPA5K_OVERRUN_EN.
module control_filtro_pa5000 (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       en1,
   output logic       en2,
   output logic       en3,
   output logic       en4,
   output logic       en5,
   output logic       en6,
   output logic       en7,
   output logic [2:0] selmuxS,
   output logic [2:0] selmuxZ,
   output logic [1:0] selmuxC,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      S4   = 3'd4,
      S5   = 3'd5,
      S6   = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic [7:1] en_q, en_d;
   logic [2:0] sel_s_q, sel_s_d;
   logic [2:0] sel_z_q, sel_z_d;
   logic [1:0] sel_c_q, sel_c_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = S1;
         S1:      state_d = S2;
         S2:      state_d = S3;
         S3:      state_d = S4;
         S4:      state_d = S5;
         S5:      state_d = S6;
         S6:      state_d = start ? S1 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies track state_q exactly.
   always_comb begin
      en_d    = 7'b0;
      sel_s_d = 3'b000;
      sel_z_d = 3'b000;
      sel_c_d = 2'b00;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      unique case (state_d)
         S1: begin en_d[5] = 1'b1; sel_s_d = 3'b001; sel_c_d = 2'b00; sel_z_d = 3'b001; end
         S2: begin en_d[2] = 1'b1; sel_s_d = 3'b010; sel_c_d = 2'b01; sel_z_d = 3'b010; end
         S3: begin en_d[6] = 1'b1; sel_s_d = 3'b000; sel_c_d = 2'b10; sel_z_d = 3'b000; end
         S4: begin en_d[7] = 1'b1; sel_s_d = 3'b011; sel_c_d = 2'b11; sel_z_d = 3'b001; end
         S5: begin en_d[1] = 1'b1; sel_s_d = 3'b100; sel_c_d = 2'b10; sel_z_d = 3'b010; end
         S6: begin en_d[3] = 1'b1; en_d[4] = 1'b1; done_d = 1'b1; end
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         en_q    <= 7'b0;
         sel_s_q <= 3'b000;
         sel_z_q <= 3'b000;
         sel_c_q <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         sel_s_q <= sel_s_d;
         sel_z_q <= sel_z_d;
         sel_c_q <= sel_c_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef CTRLPA5K_OVERRUN_EN
   logic overrun_q, overrun_d;

   // busy without done identifies S1..S5, where a new strobe would be lost.
   always_comb overrun_d = overrun_q | (start & busy_q & ~done_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overrun_q <= 1'b0;
      else        overrun_q <= overrun_d;
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

   assign {en7, en6, en5, en4, en3, en2, en1} = en_q;
   assign selmuxS = sel_s_q;
   assign selmuxZ = sel_z_q;
   assign selmuxC = sel_c_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: doc/control_filtro_pa5000.md
# control_filtro_pa5000

Sequencing control unit for the 5 kHz high-pass biquad datapath (`filtropa5000`). On each sample strobe it steps the datapath's single multiply-accumulate unit through a fixed six-step schedule. The schedule drives the register enables `en1`..`en7` and the mux selects `selmuxS`/`selmuxC`/`selmuxZ`. It then pulses `done` when `yk` holds the new output sample. It sits between the sample-rate tick (ADC conversion done) and the datapath.

## Interface
- Parameters: none. Select codes and the schedule are fixed below.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low. Shared with the datapath.
- `start`  in  1  sample strobe, sampled on the rising edge of `clk`. `uk` must be stable from this edge until `done`.
- `en1`..`en7`  out  1 each  enables for the datapath registers: `en1` yk, `en2` fk, `en3` fk1, `en4` fk2, `en5` acum1, `en6` acum2, `en7` acum3.
- `selmuxS`  out  3  summand select: 000 zero, 001 Uk, 010 acum1, 011 acum2, 100 acum3.
- `selmuxZ`  out  3  variable select: 000 fk, 001 fk1, 010 fk2, 011 yk, 100 Uk.
- `selmuxC`  out  2  coefficient select: 00 C0 = −a1, 01 C1 = −a2, 10 C2 = b0 = b2, 11 C3 = b1.
- `busy`  out  1  high in states S1..S6.
- `done`  out  1  one-cycle pulse in S6.
- `overrun`  out  1  sticky; see Configuration.

## Operation
- Moore FSM with states IDLE, S1..S6. All outputs decode from the state register only.
- Reset value of all outputs is 0: IDLE drives all enables 0, all selects 000/00, `busy` 0, `done` 0, `overrun` 0.
- IDLE: if `start`=1, go to S1; otherwise stay in IDLE.
- S1: acum1 ← Uk + C0·fk1. Drives S=001, C=00, Z=001, `en5`.
- S2: fk ← acum1 + C1·fk2. Drives S=010, C=01, Z=010, `en2`.
- S3: acum2 ← 0 + C2·fk. Drives S=000, C=10, Z=000, `en6`.
- S4: acum3 ← acum2 + C3·fk1. Drives S=011, C=11, Z=001, `en7`.
- S5: yk ← acum3 + C2·fk2. Drives S=100, C=10, Z=010, `en1`.
- S6: delay-line shift fk2 ← fk1 and fk1 ← fk in the same edge. Drives `en3`, `en4`, `done`. All selects are 000/00.
- From S6: `start`=1 goes to S1 (back-to-back samples); otherwise go to IDLE.
- S1..S5 advance unconditionally. `start` seen in S1..S5 is ignored and never queued.
- At most one enable is high in S1..S5. In S6, exactly `en3` and `en4` are high.
- The unit performs no arithmetic. Width and format are owned by `unidadaritmetica`.

## Timing
- `start` sampled high at edge k (in IDLE) puts the FSM in S1 during cycle k+1. The datapath captures at edge k+1.
- The state at edge k+n is S(n+1) for n = 0..5. `done` is high during cycle k+6.
- New `yk` is valid after edge k+5 and stays stable until the next S5.
- Latency from `start` to `done` is 6 cycles. Maximum throughput is one sample per 6 cycles (`start` held high).
- Reset asserted mid-schedule: the FSM goes to IDLE immediately with all outputs 0. No partial result is flagged. The datapath clears on the same reset.
- Reset deassertion is synchronised externally. The first legal `start` is at the first edge after release.

## Configuration
- `CTRLPA5K_OVERRUN_EN` defined: `overrun` is set at any edge where `start`=1 and the state is S1..S5. It is cleared only by `reset`.
- Not defined: `overrun` is tied to 0, with no flag logic. The FSM behaviour is identical either way.

## Test plan
- Reset with `start`=0, then release: all outputs 0 and state IDLE for 20 cycles.
- Single `start` pulse: the enable sequence over cycles 1..6 is en5, en2, en6, en7, en1, {en3,en4}. Selects are exactly as listed per state. `busy`=1 for 6 cycles. `done`=1 only in cycle 6.
- With the datapath attached and C0..C3 known: an impulse uk = 1.0 then zeros gives yk = b0, b1 − a1·b0, … matching the golden model for 8 samples.
- `start` held high for 18 cycles: exactly 3 `done` pulses, at cycles 6, 12 and 18, with S6 → S1 and no IDLE gap. `start` in S2 is ignored. `overrun`=1 with the macro and 0 without.
- `reset` pulled low in S3: all outputs 0 in the same cycle. After release and one `start`, a full clean 6-step sequence runs.
